edge_list_reporter: RTL and testbench
=====================================

EDGE_LIST_REPORTER -- requirements
Module: edge_list_reporter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL provide port `clk`, input, 1 bit: rising-edge clock, the same clock as the video processing pipeline.
REQ-003 SHALL provide port `reset`, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL provide port `sop`, input, 1 bit: frame-start pulse, the same signal that clears the edge measurement list upstream.
REQ-005 SHALL provide port `measured_list`, input, [29:0][10:0]: edge x-positions for the measured row; zero marks an unused slot.
REQ-006 SHALL provide port `out_data`, output, 32 bits: report word.
REQ-007 SHALL provide port `out_valid`, output, 1 bit: `out_data` is valid.
REQ-008 SHALL provide port `out_ready`, input, 1 bit: the sink accepts the word.
REQ-009 SHALL provide ports `out_sop` / `out_eop`, outputs, 1 bit each: first / last word of a report.
REQ-010 SHALL provide port `busy`, output, 1 bit: state is not IDLE.

Function
REQ-011 SHALL capture `measured_list` into a snapshot register on a clock edge where `sop`=1 and state=IDLE; that value is the previous frame's final list, because the upstream clear lands one edge later.
- On that edge: `frame_id` (8-bit) increments modulo 256; state goes to SCAN with `idx`=0.
REQ-012 SHALL treat `sop` as a dropped frame when state is not IDLE at the edge, including the edge on which the last word transfers.
- A dropped frame leaves the snapshot untouched and increments `drop_cnt` (8-bit, saturating at 255, cleared only by reset).
REQ-013 SHALL test one snapshot entry per cycle in SCAN.
- Entry[`idx`]==0: count=`idx`, go to HEADER.
- `idx`==29 and entry nonzero: count=30, go to HEADER.
- Otherwise `idx` increments.
REQ-014 SHALL raise `out_valid` for the header on cycle count+1 after the capture edge when count<30, and on cycle 30 when count=30.
REQ-015 SHALL form the header word as {8'hED, frame_id, drop_cnt, 3'b000, count[4:0]}, with `out_sop`=1.
REQ-016 SHALL send ceil(count/2) data words after the header.
- Word k = {5'b0, entry[2k+1], 5'b0, entry[2k]}.
- If count is odd, the upper half of the final word is zero.
REQ-017 SHALL assert `out_eop` on the last word of the report; for count=0 with the checksum excluded, the header carries both `out_sop` and `out_eop`.
REQ-018 SHALL transfer a word only on an edge where `out_valid` && `out_ready`.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_sop` and `out_eop` SHALL remain stable.
- `out_valid` SHALL NOT drop before the transfer.
REQ-019 SHALL return to IDLE on the edge where the last word transfers; `out_valid`=0 in IDLE and SCAN.
REQ-020 SHALL report entries beyond the first zero as absent: no compaction of later nonzero entries.

Reset
REQ-021 SHALL, while `reset`=1, immediately force the following regardless of `clk`:
- state=IDLE, `idx`=0
- `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `busy`=0
- `frame_id`=0, `drop_cnt`=0, snapshot=0
REQ-022 SHALL abandon a report when reset asserts mid-report, with no trailing words after release; the first `sop` after release starts a fresh report with `frame_id`=1.

Configuration
REQ-023 SHALL, when macro `EDGE_REPORT_CHECKSUM_EN` is defined, append one trailer word equal to the XOR of the header and all data words.
- The trailer carries `out_eop`; `out_eop` moves off the last data word.
- Undefined: no trailer; the report is header plus data only.

Structure
REQ-024 SHALL place in package `edge_report_pkg`:
- MAX_ENTRIES=30, X_W=11, SYNC_BYTE=8'hED
- the state enum typedef {IDLE, SCAN, HEADER, DATA, CHECK}
REQ-025 SHALL keep the FSM, snapshot and output register in one module.
- Optional sub-module `edge_pair_packer` builds data word k from the snapshot and count.

Verification
REQ-026 SHALL cover: list entries 100,200,300 then zeros, `sop`, `out_ready`=1 -> header on cycle 4 = 32'hED01_0003; data 32'h00C8_0064 (`out_sop`=0), then 32'h0000_012C with `out_eop`=1.
REQ-027 SHALL cover: all-zero list, `sop` -> header 32'hED01_0000 on cycle 1, `out_sop`=`out_eop`=1 (checksum undefined); with checksum defined -> trailer 32'hED01_0000.
REQ-028 SHALL cover: 30 nonzero entries -> header on cycle 30, count=30, 15 data words, the last carrying entries 29/28.
REQ-029 SHALL cover: `out_ready`=0 for 10 cycles during data, then a second `sop` -> words held stable, no loss; second frame dropped; next header shows `drop_cnt`=1.
REQ-030 SHALL cover: `reset` pulse during word 2 of 3 -> `out_valid`=0 at once; after the next `sop`, header `frame_id`=1.
REQ-031 SHALL cover: `sop` on the same edge as the final transfer -> dropped, `drop_cnt`+1, state IDLE.

Source files
------------

// File: rtl/edge_report_pkg.sv
// Shared types and constants for the edge list report stream.
package edge_report_pkg;

  localparam int unsigned MAX_ENTRIES = 30;
  localparam int unsigned X_W         = 11;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned K_W         = 4;
  localparam int unsigned WORD_W      = 32;
  localparam logic [7:0]  SYNC_BYTE   = 8'hED;

  typedef enum logic [2:0] {IDLE, SCAN, HEADER, DATA, CHECK} state_t;

  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] frame_id;
    logic [7:0] drop_cnt;
    logic [2:0] rsvd;
    logic [4:0] count;
  } header_t;

  function automatic logic [WORD_W-1:0] make_header(input logic [7:0] fid,
                                                    input logic [7:0] drops,
                                                    input logic [4:0] count);
    header_t h;
    h.sync     = SYNC_BYTE;
    h.frame_id = fid;
    h.drop_cnt = drops;
    h.rsvd     = 3'b000;
    h.count    = count;
    return WORD_W'(h);
  endfunction

endpackage

// File: rtl/edge_pair_packer.sv
// Builds data word k (two x-positions) from the snapshot; slots at or past count read as zero.
module edge_pair_packer
  import edge_report_pkg::*;
(
  input  logic [MAX_ENTRIES-1:0][X_W-1:0] snap,
  input  logic [IDX_W-1:0]                count,
  input  logic [K_W-1:0]                  k,
  output logic [WORD_W-1:0]               word_c
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [X_W-1:0]   lo_x;
  logic [X_W-1:0]   hi_x;

  always_comb begin
    lo_idx = {k, 1'b0};
    hi_idx = {k, 1'b1};
    lo_x   = (lo_idx < count) ? snap[lo_idx] : '0;
    hi_x   = (hi_idx < count) ? snap[hi_idx] : '0;
    word_c = {5'b00000, hi_x, 5'b00000, lo_x};
  end

endmodule

// File: rtl/edge_list_reporter.sv
// Snapshots the previous frame's edge list on sop and streams it as a header + packed data report.
// Define EDGE_REPORT_CHECKSUM_EN to append an XOR trailer word carrying out_eop.
module edge_list_reporter
  import edge_report_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sop,
  input  logic [MAX_ENTRIES-1:0][X_W-1:0] measured_list,
  output logic [WORD_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic                            busy
);

`ifdef EDGE_REPORT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t                          state_q, state_d;
  logic [MAX_ENTRIES-1:0][X_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [IDX_W-1:0]                count_q, count_d;
  logic [K_W-1:0]                  k_q, k_d;
  logic [7:0]                      frame_id_q, frame_id_d;
  logic [7:0]                      drop_cnt_q, drop_cnt_d;
  logic [WORD_W-1:0]               csum_q, csum_d;
  logic [WORD_W-1:0]               data_d;
  logic                            valid_d, sop_d, eop_d, busy_d;

  logic [IDX_W-1:0]  hdr_count_c;
  logic [IDX_W-1:0]  n_words_c;
  logic [K_W-1:0]    pack_k_c;
  logic [WORD_W-1:0] pack_word_c;
  logic              pack_last_c, last_c, xfer_c, load_c, done_c;

  edge_pair_packer u_packer (
    .snap   (snap_q),
    .count  (count_q),
    .k      (pack_k_c),
    .word_c (pack_word_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    count_d    = count_q;
    k_d        = k_q;
    frame_id_d = frame_id_q;
    drop_cnt_d = drop_cnt_q;
    csum_d     = csum_q;
    data_d     = out_data;
    valid_d    = out_valid;
    sop_d      = out_sop;
    eop_d      = out_eop;
    load_c     = 1'b0;
    done_c     = 1'b0;

    xfer_c      = out_valid & out_ready;
    hdr_count_c = (snap_q[idx_q] == '0) ? idx_q : IDX_W'(MAX_ENTRIES);
    n_words_c   = IDX_W'((count_q + IDX_W'(1)) >> 1);
    pack_k_c    = (state_q == DATA) ? k_q + K_W'(1) : '0;
    pack_last_c = ({1'b0, pack_k_c} + IDX_W'(1)) == n_words_c;
    last_c      = ({1'b0, k_q} + IDX_W'(1)) == n_words_c;

    // sop outside IDLE (even on the final transfer edge) is a dropped frame
    if (sop) begin
      if (state_q == IDLE) begin
        snap_d     = measured_list;
        frame_id_d = frame_id_q + 8'd1;
        idx_d      = '0;
        state_d    = SCAN;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      IDLE: ;
      SCAN: begin
        if ((snap_q[idx_q] == '0) || (idx_q == IDX_W'(MAX_ENTRIES - 1))) begin
          count_d = hdr_count_c;
          data_d  = make_header(frame_id_q, drop_cnt_q, hdr_count_c);
          csum_d  = make_header(frame_id_q, drop_cnt_q, hdr_count_c);
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = (hdr_count_c == '0) && !CSUM_EN;
          state_d = HEADER;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HEADER: begin
        if (xfer_c) begin
          if (count_q == '0) done_c = 1'b1;
          else               load_c = 1'b1;
        end
      end
      DATA: begin
        if (xfer_c) begin
          if (last_c) done_c = 1'b1;
          else        load_c = 1'b1;
        end
      end
      CHECK: begin
        if (xfer_c) begin
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      k_d     = pack_k_c;
      data_d  = pack_word_c;
      csum_d  = csum_q ^ pack_word_c;
      sop_d   = 1'b0;
      eop_d   = pack_last_c && !CSUM_EN;
      state_d = DATA;
    end

    // csum_q already folds in every word sent so far
    if (done_c) begin
      sop_d = 1'b0;
      if (CSUM_EN) begin
        data_d  = csum_q;
        eop_d   = 1'b1;
        state_d = CHECK;
      end else begin
        valid_d = 1'b0;
        eop_d   = 1'b0;
        state_d = IDLE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      k_q        <= '0;
      frame_id_q <= '0;
      drop_cnt_q <= '0;
      csum_q     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      k_q        <= k_d;
      frame_id_q <= frame_id_d;
      drop_cnt_q <= drop_cnt_d;
      csum_q     <= csum_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      out_sop    <= sop_d;
      out_eop    <= eop_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_edge_list_reporter.sv
// Self-checking bench for edge_list_reporter against a list-level report model.
module tb_edge_list_reporter;

  logic                 clk;
  logic                 reset;
  logic                 sop;
  logic [29:0][10:0]    measured_list;
  logic [31:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;
  logic                 busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fid_m;
  logic [7:0]  drops_m;
  logic [31:0] exp_q[$];
  int          exp_cyc;
  int          exp_cnt;

`ifdef EDGE_REPORT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  edge_list_reporter dut (
    .clk           (clk),
    .reset         (reset),
    .sop           (sop),
    .measured_list (measured_list),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count = index of first zero (or 30), then header, pairs, optional XOR trailer
  task automatic build_expected(input logic [29:0][10:0] l);
    logic [31:0] x;
    logic [10:0] lo, hi;
    int c;
    c = 30;
    for (int i = 29; i >= 0; i--) if (l[i] == 11'd0) c = i;
    exp_cnt = c;
    exp_cyc = (c < 30) ? c + 1 : 30;
    exp_q.delete();
    exp_q.push_back({8'hED, fid_m, drops_m, 3'b000, 5'(c)});
    for (int k = 0; 2 * k < c; k++) begin
      lo = l[2 * k];
      hi = (2 * k + 1 < c) ? l[2 * k + 1] : 11'd0;
      exp_q.push_back({5'b00000, hi, 5'b00000, lo});
    end
    if (CSUM) begin
      x = 32'd0;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sop = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fid_m = 8'd0; drops_m = 8'd0;
  endtask

  task automatic pulse_sop();
    sop = 1'b1;
    @(negedge clk);
    sop = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Holds out_ready low for 'stall' cycles watching the word, then transfers it
  task automatic get_word(input int stall, output logic [31:0] d, output logic s,
                          output logic e, output logic v, output logic stable);
    stable = 1'b1;
    v = out_valid; d = out_data; s = out_sop; e = out_eop;
    out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d || out_sop !== s || out_eop !== e) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic collect_from(input int first, input int max_stall, output int bad);
    logic [31:0] d;
    logic s, e, v, st;
    bad = 0;
    for (int i = first; i < exp_q.size(); i++) begin
      get_word(int'($urandom_range(max_stall, 0)), d, s, e, v, st);
      if (v !== 1'b1 || st !== 1'b1 || d !== exp_q[i] ||
          s !== (i == 0) || e !== (i == exp_q.size() - 1)) bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sop = 1'b0; out_ready = 1'b0; measured_list = '0;
    #1 reset = 1'b1;
    sop = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, busy, out_data} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b sop=%b eop=%b busy=%b data=%h, want all zero",
               out_valid, out_sop, out_eop, busy, out_data);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds: busy=%b valid=%b with sop during reset, want 0/0", busy, out_valid);
    end
    sop = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    fid_m = 8'd0; drops_m = 8'd0;
  endtask

  task automatic test_three_entries();
    logic [29:0][10:0] l;
    logic [31:0] d; logic s, e, v, st;
    int cyc, bad;
    do_reset();
    l = '0; l[0] = 11'd100; l[1] = 11'd200; l[2] = 11'd300;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    measured_list = '0;
    wait_valid(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL three_latency: got cycle %0d, want 4", cyc); end
    get_word(0, d, s, e, v, st);
    checks++;
    if (d !== 32'hED01_0003 || s !== 1'b1 || e !== 1'b0 || v !== 1'b1) begin
      errors++; $display("FAIL three_header: got %h sop=%b eop=%b, want ED010003 sop=1 eop=0", d, s, e);
    end
    get_word(0, d, s, e, v, st);
    checks++;
    if (d !== 32'h00C8_0064 || s !== 1'b0 || e !== 1'b0) begin
      errors++; $display("FAIL three_data0: got %h sop=%b eop=%b, want 00C80064 sop=0 eop=0", d, s, e);
    end
    get_word(0, d, s, e, v, st);
    checks++;
    if (d !== 32'h0000_012C || s !== 1'b0 || e !== (exp_q.size() == 3)) begin
      errors++; $display("FAIL three_data1: got %h sop=%b eop=%b, want 0000012C eop=%b", d, s, e, exp_q.size() == 3);
    end
    collect_from(3, 0, bad);
    checks++;
    if (bad !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL three_tail: %0d bad trailing words, busy=%b, want 0/0", bad, busy);
    end
  endtask

  task automatic test_empty_list();
    logic [31:0] d; logic s, e, v, st;
    int cyc, bad;
    do_reset();
    measured_list = '0;
    fid_m++; build_expected('0);
    pulse_sop();
    wait_valid(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL empty_latency: got cycle %0d, want 1", cyc); end
    get_word(1, d, s, e, v, st);
    checks++;
    if (d !== 32'hED01_0000 || s !== 1'b1 || e !== (exp_q.size() == 1) || st !== 1'b1) begin
      errors++; $display("FAIL empty_header: got %h sop=%b eop=%b, want ED010000 sop=1 eop=%b", d, s, e, exp_q.size() == 1);
    end
    collect_from(1, 0, bad);
    checks++;
    if (bad !== 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_trailer: %0d bad words, valid=%b, want 0/0", bad, out_valid);
    end
  endtask

  task automatic test_full_list();
    logic [29:0][10:0] l;
    logic [31:0] w[$];
    logic [31:0] d; logic s, e, v, st;
    int cyc, bad;
    for (int i = 0; i < 30; i++) l[i] = 11'($urandom_range(2047, 1));
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    measured_list = '0;
    wait_valid(cyc);
    checks++;
    if (cyc !== 30 || out_data[4:0] !== 5'd30) begin
      errors++; $display("FAIL full_header: cycle %0d count %0d, want 30/30", cyc, out_data[4:0]);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      get_word(0, d, s, e, v, st);
      w.push_back(d);
      if (v !== 1'b1 || d !== exp_q[i] || s !== (i == 0) || e !== (i == exp_q.size() - 1)) bad++;
    end
    checks++;
    if (bad !== 0 || exp_q.size() !== 16 + int'(CSUM)) begin
      errors++; $display("FAIL full_words: %0d bad of %0d words", bad, exp_q.size());
    end
    checks++;
    if (w[15] !== {5'b00000, l[29], 5'b00000, l[28]}) begin
      errors++; $display("FAIL full_last_pair: got %h, want entries 29/28 %h/%h", w[15], l[29], l[28]);
    end
  endtask

  task automatic test_backpressure();
    logic [29:0][10:0] l;
    logic [31:0] d, d0; logic s, e, v, st, s0, e0, stable;
    int cyc, bad;
    do_reset();
    l = '0;
    for (int i = 0; i < 5; i++) l[i] = 11'($urandom_range(2047, 1));
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    get_word(0, d, s, e, v, st);
    get_word(0, d, s, e, v, st);
    checks++;
    if (d !== exp_q[1]) begin errors++; $display("FAIL bp_data0: got %h, want %h", d, exp_q[1]); end
    d0 = out_data; s0 = out_sop; e0 = out_eop; stable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sop = (i == 3);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_sop !== s0 || out_eop !== e0) stable = 1'b0;
    end
    sop = 1'b0;
    drops_m++;
    checks++;
    if (stable !== 1'b1 || d0 !== exp_q[2] || busy !== 1'b1) begin
      errors++; $display("FAIL bp_hold: stable=%b word %h busy=%b, want 1 %h 1", stable, d0, busy, exp_q[2]);
    end
    collect_from(2, 2, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_drain: %0d bad words, want 0", bad); end
    l = '0; l[0] = 11'd5; l[1] = 11'd6;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    checks++;
    if (out_data !== exp_q[0] || out_data[15:8] !== 8'd1) begin
      errors++; $display("FAIL bp_drop_cnt: got header %h, want %h (drop_cnt 1)", out_data, exp_q[0]);
    end
    collect_from(0, 1, bad);
  endtask

  task automatic test_reset_mid();
    logic [29:0][10:0] l;
    logic [31:0] d; logic s, e, v, st, quiet;
    int cyc, bad;
    do_reset();
    l = '0; l[0] = 11'd100; l[1] = 11'd200; l[2] = 11'd300;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    get_word(0, d, s, e, v, st);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sop !== 1'b0 || out_data !== 32'd0) begin
      errors++; $display("FAIL midreset_async: valid=%b busy=%b sop=%b data=%h, want all zero",
                         out_valid, busy, out_sop, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    fid_m = 8'd0; drops_m = 8'd0;
    quiet = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL midreset_trailing: valid seen after release, want none"); end
    l = '0; l[0] = 11'd7;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    checks++;
    if (out_data !== exp_q[0] || out_data[23:16] !== 8'h01) begin
      errors++; $display("FAIL midreset_frame_id: got header %h, want %h (frame_id 1)", out_data, exp_q[0]);
    end
    collect_from(0, 0, bad);
  endtask

  task automatic test_sop_on_last();
    logic [29:0][10:0] l;
    logic [31:0] d; logic s, e, v, st;
    int cyc, bad;
    l = '0; l[0] = 11'($urandom_range(2047, 1));
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    for (int i = 0; i < exp_q.size() - 1; i++) get_word(0, d, s, e, v, st);
    checks++;
    if (out_valid !== 1'b1 || out_eop !== 1'b1 || out_data !== exp_q[exp_q.size() - 1]) begin
      errors++; $display("FAIL lastsop_word: got %h valid=%b eop=%b, want %h 1 1",
                         out_data, out_valid, out_eop, exp_q[exp_q.size() - 1]);
    end
    out_ready = 1'b1; sop = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; sop = 1'b0;
    drops_m++;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lastsop_idle: busy=%b valid=%b, want 0/0", busy, out_valid);
    end
    l = '0; l[0] = 11'd9; l[1] = 11'd10;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    checks++;
    if (out_data !== exp_q[0]) begin
      errors++; $display("FAIL lastsop_drop_cnt: got header %h, want %h", out_data, exp_q[0]);
    end
    collect_from(0, 0, bad);
  endtask

  task automatic test_random_frames();
    logic [29:0][10:0] l;
    logic [31:0] d; logic s, e, v, st;
    int cyc, c;
    for (int f = 0; f < 16; f++) begin
      c = int'($urandom_range(30, 0));
      for (int i = 0; i < 30; i++) begin
        if (i < c)       l[i] = 11'($urandom_range(2047, 1));
        else if (i == c) l[i] = 11'd0;
        else             l[i] = ($urandom_range(1, 0) == 1) ? 11'($urandom_range(2047, 1)) : 11'd0;
      end
      measured_list = l;
      fid_m++; build_expected(l);
      pulse_sop();
      for (int i = 0; i < 30; i++) measured_list[i] = 11'($urandom);
      wait_valid(cyc);
      checks++;
      if (cyc !== exp_cyc) begin
        errors++; $display("FAIL rand_latency f%0d: got cycle %0d, want %0d (count %0d)", f, cyc, exp_cyc, exp_cnt);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        get_word(int'($urandom_range(3, 0)), d, s, e, v, st);
        checks++;
        if (v !== 1'b1 || st !== 1'b1 || d !== exp_q[i] || s !== (i == 0) || e !== (i == exp_q.size() - 1)) begin
          errors++; $display("FAIL rand_word f%0d w%0d: got %h v=%b stable=%b sop=%b eop=%b, want %h sop=%b eop=%b",
                             f, i, d, v, st, s, e, exp_q[i], i == 0, i == exp_q.size() - 1);
        end
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL rand_end f%0d: busy=%b valid=%b, want 0/0", f, busy, out_valid);
      end
    end
  endtask

  task automatic test_drop_saturate();
    logic [29:0][10:0] l;
    int cyc, bad, dsum;
    l = '0; l[0] = 11'd1; l[1] = 11'd2; l[2] = 11'd3;
    measured_list = l;
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    sop = 1'b1;
    repeat (300) @(negedge clk);
    sop = 1'b0;
    dsum = int'(drops_m) + 300;
    drops_m = (dsum > 255) ? 8'hFF : 8'(dsum);
    checks++;
    if (busy !== 1'b1 || out_data !== exp_q[0]) begin
      errors++; $display("FAIL sat_hold: busy=%b header %h, want 1 %h", busy, out_data, exp_q[0]);
    end
    collect_from(0, 0, bad);
    fid_m++; build_expected(l);
    pulse_sop();
    wait_valid(cyc);
    checks++;
    if (out_data !== exp_q[0] || out_data[15:8] !== 8'hFF) begin
      errors++; $display("FAIL sat_drop_cnt: got header %h, want %h (drop_cnt FF)", out_data, exp_q[0]);
    end
    collect_from(0, 0, bad);
  endtask

  initial begin
    test_reset();
    test_three_entries();
    test_empty_list();
    test_full_list();
    test_backpressure();
    test_reset_mid();
    test_sop_on_last();
    test_random_frames();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
